// File: rtl/spi_pwm_pkg.sv
// Shared definitions for the SPI-facing PWM register bank: address map, bit
// positions within STATUS/CTRL, and the packed PWM configuration record.
package spi_pwm_pkg;

  localparam int unsigned REG_W = 8;

  localparam logic [3:0] ADDR_CTRL   = 4'h0;
  localparam logic [3:0] ADDR_PERIOD = 4'h1;
  localparam logic [3:0] ADDR_DUTY0  = 4'h2;
  localparam logic [3:0] ADDR_DUTY1  = 4'h3;
  localparam logic [3:0] ADDR_COMMIT = 4'h4;
  localparam logic [3:0] ADDR_STATUS = 4'h5;
  localparam logic [3:0] ADDR_WRCNT  = 4'h6;
  localparam logic [3:0] ADDR_ID     = 4'h7;

  localparam int unsigned ST_DIRTY = 0;
  localparam int unsigned ST_ERR   = 1;

  localparam int unsigned CTRL_EN  = 0;
  localparam int unsigned CTRL_INV = 1;

  typedef logic [REG_W-1:0] reg_t;

  typedef struct packed {
    reg_t ctrl;
    reg_t period;
    reg_t duty0;
    reg_t duty1;
  } pwm_cfg_t;

endpackage

// File: rtl/spi_wr_strobe.sv
// Converts the SPI slave's level write request into a single-edge strobe per
// frame; the edge-detect flop is cleared whenever the frame ends (cs high).
module spi_wr_strobe (
  input  logic sclk,
  input  logic rst_n,
  input  logic cs,
  input  logic wr_en,
  output logic wr_stb
);

  logic wr_q;
  logic wr_d;
  logic clr_n;

  // Frame end and reset share one asynchronous clear of the edge detector.
  assign clr_n = rst_n & ~cs;
  assign wr_d  = wr_en;

  always_ff @(posedge sclk or negedge clr_n) begin
    if (!clr_n) begin
      wr_q <= 1'b0;
    end else begin
      wr_q <= wr_d;
    end
  end

  assign wr_stb = wr_en & ~wr_q;

endmodule

// File: rtl/spi_reg_bank.sv
// Double-buffered PWM configuration registers behind the SPI slave, with
// status, write counter and ID read-back; all state in the SCLK domain.
module spi_reg_bank #(
  parameter logic [7:0] ID_VALUE   = 8'hA5,
  parameter logic [7:0] PERIOD_RST = 8'hFF,
  parameter logic [7:0] DUTY_RST   = 8'h00
) (
  input  logic       sclk,
  input  logic       rst_n,
  input  logic       cs,
  input  logic [3:0] addr,
  input  logic [7:0] data_wr,
  input  logic       wr_en,
  output logic [7:0] data_rd,
  output logic [7:0] pwm_ctrl,
  output logic [7:0] pwm_period,
  output logic [7:0] pwm_duty0,
  output logic [7:0] pwm_duty1
);

  import spi_pwm_pkg::*;

  localparam pwm_cfg_t CfgRst = '{
    ctrl:   8'h00,
    period: PERIOD_RST,
    duty0:  DUTY_RST,
    duty1:  DUTY_RST
  };

  logic     wr_stb;
  pwm_cfg_t shadow_q, shadow_d;
  pwm_cfg_t active_q, active_d;
  logic     dirty_q, dirty_d;
  logic     err_q, err_d;
  reg_t     wrcnt_q, wrcnt_d;

  spi_wr_strobe u_wr_strobe (
    .sclk   (sclk),
    .rst_n  (rst_n),
    .cs     (cs),
    .wr_en  (wr_en),
    .wr_stb (wr_stb)
  );

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    dirty_d  = dirty_q;
    err_d    = err_q;
    wrcnt_d  = wrcnt_q;
    if (wr_stb) begin
      if (wrcnt_q != 8'hFF) begin
        wrcnt_d = wrcnt_q + 8'd1;
      end
      case (addr)
        ADDR_CTRL: begin
          shadow_d.ctrl = data_wr;
          dirty_d       = 1'b1;
        end
        ADDR_PERIOD: begin
          shadow_d.period = data_wr;
          dirty_d         = 1'b1;
        end
        ADDR_DUTY0: begin
          shadow_d.duty0 = data_wr;
          dirty_d        = 1'b1;
        end
        ADDR_DUTY1: begin
          shadow_d.duty1 = data_wr;
          dirty_d        = 1'b1;
        end
        ADDR_COMMIT: begin
          if (data_wr[0]) begin
            active_d = shadow_q;
            dirty_d  = 1'b0;
          end
        end
        ADDR_STATUS: begin
          if (data_wr[ST_ERR]) begin
            err_d = 1'b0;
          end
        end
        // WRCNT, ID and the unmapped range reject writes.
        default: begin
          err_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= CfgRst;
      active_q <= CfgRst;
      dirty_q  <= 1'b0;
      err_q    <= 1'b0;
      wrcnt_q  <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      dirty_q  <= dirty_d;
      err_q    <= err_d;
      wrcnt_q  <= wrcnt_d;
    end
  end

  always_comb begin
    data_rd = '0;
    case (addr)
      ADDR_CTRL:   data_rd = shadow_q.ctrl;
      ADDR_PERIOD: data_rd = shadow_q.period;
      ADDR_DUTY0:  data_rd = shadow_q.duty0;
      ADDR_DUTY1:  data_rd = shadow_q.duty1;
      ADDR_STATUS: begin
        data_rd[ST_DIRTY] = dirty_q;
        data_rd[ST_ERR]   = err_q;
      end
      ADDR_WRCNT:  data_rd = wrcnt_q;
      ADDR_ID:     data_rd = ID_VALUE;
      default:     data_rd = '0;
    endcase
  end

  assign pwm_ctrl   = active_q.ctrl;
  assign pwm_period = active_q.period;
  assign pwm_duty0  = active_q.duty0;
  assign pwm_duty1  = active_q.duty1;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Scoreboard bench for spi_reg_bank: stimulus updates a register-map model and
// queues expected read-back/outputs; a monitor pops and compares on negedge.
module tb_spi_reg_bank;

  logic       sclk;
  logic       rst_n;
  logic       cs;
  logic [3:0] addr;
  logic [7:0] data_wr;
  logic       wr_en;
  logic [7:0] data_rd;
  logic [7:0] pwm_ctrl;
  logic [7:0] pwm_period;
  logic [7:0] pwm_duty0;
  logic [7:0] pwm_duty1;

  spi_reg_bank dut (
    .sclk       (sclk),
    .rst_n      (rst_n),
    .cs         (cs),
    .addr       (addr),
    .data_wr    (data_wr),
    .wr_en      (wr_en),
    .data_rd    (data_rd),
    .pwm_ctrl   (pwm_ctrl),
    .pwm_period (pwm_period),
    .pwm_duty0  (pwm_duty0),
    .pwm_duty1  (pwm_duty1)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  typedef struct {
    logic [3:0] a;
    logic [7:0] rd;
    logic [7:0] ctrl;
    logic [7:0] period;
    logic [7:0] duty0;
    logic [7:0] duty1;
  } item_t;

  item_t exp_q[$];
  int    n_cmp;
  int    n_bad;

  // Reference model: register map as plain arrays and counters.
  logic [7:0] m_sh[4];
  logic [7:0] m_act[4];
  bit         m_dirty;
  bit         m_err;
  int         m_cnt;

  function automatic void model_reset();
    m_sh[0] = 8'h00; m_sh[1] = 8'hFF; m_sh[2] = 8'h00; m_sh[3] = 8'h00;
    for (int i = 0; i < 4; i++) m_act[i] = m_sh[i];
    m_dirty = 0;
    m_err   = 0;
    m_cnt   = 0;
  endfunction

  function automatic void model_write(int a, logic [7:0] d);
    if (m_cnt < 255) m_cnt++;
    if (a < 4) begin
      m_sh[a] = d;
      m_dirty = 1;
    end else if (a == 4) begin
      if (d[0]) begin
        for (int i = 0; i < 4; i++) m_act[i] = m_sh[i];
        m_dirty = 0;
      end
    end else if (a == 5) begin
      if (d[1]) m_err = 0;
    end else begin
      m_err = 1;
    end
  endfunction

  function automatic logic [7:0] model_read(int a);
    if (a < 4) return m_sh[a];
    if (a == 5) return {6'd0, m_err, m_dirty};
    if (a == 6) return 8'(m_cnt);
    if (a == 7) return 8'hA5;
    return 8'h00;
  endfunction

  function automatic void push_exp(int a);
    item_t it;
    it.a      = 4'(a);
    it.rd     = model_read(a);
    it.ctrl   = m_act[0];
    it.period = m_act[1];
    it.duty0  = m_act[2];
    it.duty1  = m_act[3];
    exp_q.push_back(it);
  endfunction

  function automatic void cmp(string name, logic [3:0] a, logic [7:0] got, logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s addr=0x%0h got=0x%02h expected=0x%02h", name, a, got, want);
    end
  endfunction

  // Monitor: the DUT's outputs are combinational, so each queued item is
  // compared at the first falling edge after it is posted.
  initial begin
    item_t it;
    n_cmp = 0;
    n_bad = 0;
    forever begin
      @(negedge sclk);
      if (exp_q.size() > 0) begin
        it = exp_q.pop_front();
        cmp("data_rd", it.a, data_rd, it.rd);
        cmp("pwm_ctrl", it.a, pwm_ctrl, it.ctrl);
        cmp("pwm_period", it.a, pwm_period, it.period);
        cmp("pwm_duty0", it.a, pwm_duty0, it.duty0);
        cmp("pwm_duty1", it.a, pwm_duty1, it.duty1);
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge sclk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout pending=%0d expected=0", exp_q.size());
      exp_q.delete();
    end
    #1;
  endtask

  task automatic check(int a);
    @(posedge sclk);
    #2;
    addr = 4'(a);
    push_exp(a);
    drain();
  endtask

  // One SPI frame: wr_en held for `edges` rising edges, then one idle edge.
  task automatic frame(int a, logic [7:0] d, int edges, bit mid_chk);
    @(posedge sclk);
    #2;
    cs      = 1'b0;
    addr    = 4'(a);
    data_wr = d;
    wr_en   = 1'b1;
    for (int i = 0; i < edges; i++) begin
      @(posedge sclk);
      if (i == 0) model_write(a, d);
      if (i == 0 && mid_chk) push_exp(a);
    end
    #2;
    wr_en = 1'b0;
    @(posedge sclk);
    #2;
    cs = 1'b1;
    drain();
  endtask

  initial begin
    rst_n   = 1'b0;
    cs      = 1'b1;
    addr    = '0;
    data_wr = '0;
    wr_en   = 1'b0;
    model_reset();
    #12;
    rst_n = 1'b1;

    check(7); check(5); check(6); check(0);

    frame(1, 8'h40, 5, 1'b0);
    check(1); check(5); check(6);

    frame(4, 8'h01, 3, 1'b1);
    check(5); check(6); check(4);

    frame(7, 8'h12, 1, 1'b0);
    frame(4'hB, 8'h34, 2, 1'b0);
    check(7); check(5); check(6); check(4'hB);
    frame(5, 8'h02, 2, 1'b0);
    check(5);

    for (int n = 0; n < 60; n++) begin
      int a;
      a = (($urandom_range(0, 3) == 0) ? 4 : int'($urandom_range(0, 15)));
      frame(a, 8'($urandom), int'($urandom_range(1, 4)), 1'b0);
      check(int'($urandom_range(0, 15)));
    end

    for (int n = 0; n < 300; n++) begin
      frame(int'($urandom_range(0, 15)), 8'($urandom), int'($urandom_range(1, 3)), 1'b0);
    end
    check(6); check(5);

    // Reset in the middle of a frame while dirty is set.
    frame(0, 8'h3C, 1, 1'b0);
    @(posedge sclk);
    #2;
    cs      = 1'b0;
    addr    = 4'h2;
    data_wr = 8'h77;
    wr_en   = 1'b1;
    @(posedge sclk);
    model_write(2, 8'h77);
    #2;
    rst_n = 1'b0;
    wr_en = 1'b0;
    cs    = 1'b1;
    model_reset();
    push_exp(2);
    drain();
    @(posedge sclk);
    #2;
    rst_n = 1'b1;
    check(0); check(5); check(6);
    frame(3, 8'h5A, 2, 1'b0);
    check(3); check(5); check(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_reg_bank.md
Name: spi_reg_bank

Overview:
- Register bank directly downstream of the SPI slave front-end, in the SCLK domain.
- Turns the slave's level write enable into one write per SPI frame and holds double-buffered (shadow/active) PWM configuration.
- Returns combinational read-back data to the slave's read path.
- Active registers feed the PWM generator; shadow-to-active transfer is an explicit atomic commit.

Parameters:
- ID_VALUE, 8'hA5, constant returned at address 0x7.
- PERIOD_RST, 8'hFF, reset value of shadow and active PERIOD.
- DUTY_RST, 8'h00, reset value of shadow and active DUTY0/DUTY1.

Ports:
- sclk  in  1  SPI clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cs  in  1  SPI chip select, active-low frame; high asynchronously clears the write-edge flag.
- addr  in  4  register address from the SPI slave.
- data_wr  in  8  write data from the SPI slave.
- wr_en  in  1  level write request; stays high until the end of the frame.
- data_rd  out  8  read-back data for addr (combinational).
- pwm_ctrl  out  8  active CTRL (bit0 enable, bit1 invert).
- pwm_period  out  8  active PERIOD.
- pwm_duty0  out  8  active DUTY0.
- pwm_duty1  out  8  active DUTY1.

Behaviour:
- Write strobe
  - wr_q samples wr_en on each rising sclk; wr_q is async-cleared by rst_n=0 or cs=1.
  - Accepted write (wr_stb) = wr_en & ~wr_q, sampled on a rising sclk. At most one write per frame.
  - The host must supply at least one SCLK edge after the data byte while cs is low; otherwise no write occurs.
  - wr_en held high for N further edges: exactly one write.
- Register map
  - 0x0 CTRL: rw shadow.
  - 0x1 PERIOD: rw shadow.
  - 0x2 DUTY0: rw shadow.
  - 0x3 DUTY1: rw shadow.
  - 0x4 COMMIT: wo. Writing with bit0=1 copies all four shadows to active on that edge and clears dirty. bit0=0 has no effect. Reads 0x00.
  - 0x5 STATUS: bit0 dirty (ro), bit1 err (sticky, W1C), other bits read 0.
  - 0x6 WRCNT: ro count of accepted strobes, all addresses included, saturating at 8'hFF.
  - 0x7 ID: ro, reads ID_VALUE.
  - 0x8-0xF: unmapped, read 0x00.
- dirty: set by any write to 0x0-0x3; cleared by COMMIT with bit0=1.
- err: set by a write to 0x6, 0x7 or 0x8-0xF.
- STATUS write: data bit1=1 clears err; sets err only if the address is invalid (never, since 0x5 is valid).
- Read-only and unmapped writes: contents unchanged, err set, WRCNT increments.
- Reads of 0x0-0x3 return shadow values, not active.
- Reset (async)
  - Shadow and active: CTRL=0x00, PERIOD=PERIOD_RST, DUTY0/1=DUTY_RST.
  - dirty=0, err=0, WRCNT=0, wr_q=0.
  - Outputs therefore reset to 0x00/PERIOD_RST/DUTY_RST; data_rd follows addr.
- Reset mid-frame: all state returns to reset values immediately. No partial write; the strobe is lost.
- cs high mid-frame: register contents unaffected; only wr_q clears.
- Latency: shadow, STATUS and WRCNT update on the strobe edge; active outputs change on the COMMIT strobe edge only.

Decomposition:
- Shared package spi_pwm_pkg:
  - address localparams ADDR_CTRL…ADDR_ID;
  - STATUS bit indices (ST_DIRTY=0, ST_ERR=1);
  - CTRL bit indices (CTRL_EN=0, CTRL_INV=1);
  - register width 8.
- One sub-module, spi_wr_strobe: wr_q flop with async clear on rst_n/cs; outputs wr_stb.

Test Plan:
- Reset → pwm_period=0xFF, pwm_duty0=0x00, pwm_ctrl=0x00; read 0x7=0xA5, 0x5=0x00, 0x6=0x00.
- Write 0x1=0x40 with wr_en held 5 edges → shadow reads 0x40, STATUS=0x01, WRCNT=1, pwm_period still 0xFF.
- Write 0x4=0x01 → pwm_period=0x40 on the strobe edge, STATUS=0x00, WRCNT=2; a later read of 0x4 returns 0x00.
- Write 0x7=0x12, then 0xB=0x34 → ID still 0xA5, STATUS bit1=1, WRCNT+2; write 0x5=0x02 → STATUS bit1=0.
- 300 single-write frames → WRCNT=0xFF, no wrap.
- Assert rst_n low with dirty=1 mid-frame → all registers back to reset values; the next frame after release writes normally.
